// File: rtl/sop_sbox_sched.sv
// Issue scheduler for the two-stage masked AES S-box core: round-robin arbitration,
// one fresh randomness word per operation, stage enables and result tagging.
// Optional stuck-PRNG detection is compiled in with `define SOP_RND_CHK_EN.
module sop_sbox_sched #(
  parameter int RND_W = 15,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           req_ready,
  input  logic [RND_W-1:0]     rnd_in,
  input  logic                 rnd_in_valid,
  output logic                 rnd_in_ready,
  output logic                 core_sel,
  output logic [RND_W-1:0]     core_rnd,
  output logic                 core_en_s1,
  output logic                 core_en_s2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_src,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy,
  output logic                 rnd_err
);

  logic [TAG_W-1:0] tag_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tag
      assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
    end
  endgenerate

  logic [RND_W-1:0] rbuf_q, rbuf_d;
  logic             rbuf_vld_q, rbuf_vld_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_src_q, s1_src_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_vld_q, s2_vld_d;
  logic             s2_src_q, s2_src_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             rr_last_q, rr_last_d;

  logic adv1, adv2, issue, gnt_id, rnd_load, rnd_blk;

`ifdef SOP_RND_CHK_EN
  logic [RND_W-1:0] rnd_prev_q, rnd_prev_d;
  logic             rnd_err_q, rnd_err_d;

  assign rnd_blk = rnd_err_q;
  assign rnd_err = rnd_err_q;

  always_comb begin
    rnd_prev_d = rnd_prev_q;
    rnd_err_d  = rnd_err_q;
    if (rnd_load) begin
      rnd_prev_d = rnd_in;
      if (rnd_in == rnd_prev_q) rnd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_prev_q <= '0;
      rnd_err_q  <= 1'b0;
    end else begin
      rnd_prev_q <= rnd_prev_d;
      rnd_err_q  <= rnd_err_d;
    end
  end
`else
  assign rnd_blk = 1'b0;
  assign rnd_err = 1'b0;
`endif

  // Stage 2 frees up when empty or consumed; stage 1 moves only into a free stage 2.
  always_comb begin
    adv2     = !s2_vld_q | out_ready;
    adv1     = s1_vld_q & adv2;
    gnt_id   = (&req_valid) ? ~rr_last_q : req_valid[1];
    issue    = (|req_valid) & rbuf_vld_q & (!s1_vld_q | adv1) & !rnd_blk;
    rnd_load = rnd_in_valid & (!rbuf_vld_q | issue);
  end

  assign req_ready    = issue ? {gnt_id, ~gnt_id} : 2'b00;
  assign rnd_in_ready = !rbuf_vld_q | issue;
  assign core_sel     = gnt_id;
  assign core_rnd     = rbuf_q;
  assign core_en_s1   = issue;
  assign core_en_s2   = adv1;
  assign out_valid    = s2_vld_q;
  assign out_src      = s2_src_q;
  assign out_tag      = s2_tag_q;
  assign busy         = s1_vld_q | s2_vld_q;

  always_comb begin
    rbuf_d     = rbuf_q;
    rbuf_vld_d = rbuf_vld_q;
    s1_vld_d   = s1_vld_q;
    s1_src_d   = s1_src_q;
    s1_tag_d   = s1_tag_q;
    s2_vld_d   = s2_vld_q;
    s2_src_d   = s2_src_q;
    s2_tag_d   = s2_tag_q;
    rr_last_d  = rr_last_q;

    // A consumed word is dropped unless refilled in the same cycle.
    if (rnd_load) begin
      rbuf_d     = rnd_in;
      rbuf_vld_d = 1'b1;
    end else if (issue) begin
      rbuf_vld_d = 1'b0;
    end

    if (issue) begin
      s1_vld_d  = 1'b1;
      s1_src_d  = gnt_id;
      s1_tag_d  = tag_arr[gnt_id];
      rr_last_d = gnt_id;
    end else if (adv1) begin
      s1_vld_d = 1'b0;
    end

    if (adv1) begin
      s2_vld_d = 1'b1;
      s2_src_d = s1_src_q;
      s2_tag_d = s1_tag_q;
    end else if (out_ready & s2_vld_q) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_q     <= '0;
      rbuf_vld_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_src_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_src_q   <= 1'b0;
      s2_tag_q   <= '0;
      rr_last_q  <= 1'b1;
    end else begin
      rbuf_q     <= rbuf_d;
      rbuf_vld_q <= rbuf_vld_d;
      s1_vld_q   <= s1_vld_d;
      s1_src_q   <= s1_src_d;
      s1_tag_q   <= s1_tag_d;
      s2_vld_q   <= s2_vld_d;
      s2_src_q   <= s2_src_d;
      s2_tag_q   <= s2_tag_d;
      rr_last_q  <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_sop_sbox_sched.sv
// Directed bench for sop_sbox_sched: single op, contention, backpressure,
// randomness starvation, mid-flight reset and (with SOP_RND_CHK_EN) stuck-PRNG detection.
module tb_sop_sbox_sched;
  localparam int RND_W = 15;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [2*TAG_W-1:0] req_tag;
  logic [1:0]         req_ready;
  logic [RND_W-1:0]   rnd_in;
  logic               rnd_in_valid;
  logic               rnd_in_ready;
  logic               core_sel;
  logic [RND_W-1:0]   core_rnd;
  logic               core_en_s1;
  logic               core_en_s2;
  logic               out_valid;
  logic               out_ready;
  logic               out_src;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;
  logic               rnd_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sop_sbox_sched #(.RND_W(RND_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .rnd_in(rnd_in), .rnd_in_valid(rnd_in_valid), .rnd_in_ready(rnd_in_ready),
    .core_sel(core_sel), .core_rnd(core_rnd),
    .core_en_s1(core_en_s1), .core_en_s2(core_en_s2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_tag(out_tag),
    .busy(busy), .rnd_err(rnd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid    = 2'b00;
    req_tag      = '0;
    rnd_in       = '0;
    rnd_in_valid = 1'b0;
    out_ready    = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rnd_in_ready", 32'(rnd_in_ready), 32'd1);
    chk("rst_rnd_err", 32'(rnd_err), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // ---- 1: single op ----
    do_reset();
    rnd_in = 15'h1234; rnd_in_valid = 1'b1;
    tick();
    rnd_in_valid = 1'b0; req_valid = 2'b01; req_tag = 8'h05;
    @(negedge clk);
    $display("t1 issue: req_ready=%b rnd=%h", req_ready, core_rnd);
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_en_s1", 32'(core_en_s1), 32'd1);
    chk("t1_core_rnd", 32'(core_rnd), 32'h1234);
    chk("t1_core_sel", 32'(core_sel), 32'd0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_en_s2", 32'(core_en_s2), 32'd1);
    chk("t1_no_early_out", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    $display("t1 result: out_valid=%b src=%b tag=%h", out_valid, out_src, out_tag);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_src", 32'(out_src), 32'd0);
    chk("t1_out_tag", 32'(out_tag), 32'h5);
    tick();
    @(negedge clk);
    chk("t1_drained", 32'(busy), 32'd0);

    // ---- 2: contention, grants 0,1,0,1 ----
    do_reset();
    rnd_in = 15'h100; rnd_in_valid = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      req_valid = (i < 4) ? 2'b11 : 2'b00;
      req_tag   = {4'(8 + i), 4'(i)};
      rnd_in    = 15'(16'h101 + i);
      @(negedge clk);
      $display("t2 cyc%0d: req_ready=%b out_valid=%b src=%b tag=%h",
               i, req_ready, out_valid, out_src, out_tag);
      if (i < 4) begin
        chk("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_core_rnd", 32'(core_rnd), 32'h100 + 32'(i));
      end
      if (i >= 2 && i < 6) begin
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_src", 32'(out_src), 32'((i - 2) % 2));
        chk("t2_out_tag", 32'(out_tag), ((i - 2) % 2 == 1) ? 32'(8 + i - 2) : 32'(i - 2));
      end
      if (i == 6) chk("t2_out_done", 32'(out_valid), 32'd0);
      tick();
    end

    // ---- 3: backpressure ----
    do_reset();
    rnd_in = 15'h200; rnd_in_valid = 1'b1;
    tick();
    begin
      int issues;
      issues = 0;
      out_ready = 1'b0;
      req_valid = 2'b01;
      for (int c = 0; c < 5; c++) begin
        req_tag = {4'h0, 4'(c + 1)};
        rnd_in  = 15'(16'h201 + c);
        @(negedge clk);
        $display("t3 cyc%0d: en_s1=%b out_valid=%b tag=%h", c, core_en_s1, out_valid, out_tag);
        if (core_en_s1) issues++;
        chk("t3_issue", 32'(core_en_s1), (c < 2) ? 32'd1 : 32'd0);
        if (c >= 2) begin
          chk("t3_hold_valid", 32'(out_valid), 32'd1);
          chk("t3_hold_tag", 32'(out_tag), 32'h1);
          chk("t3_hold_src", 32'(out_src), 32'd0);
        end
        tick();
      end
      chk("t3_issue_count", 32'(issues), 32'd2);
    end
    out_ready = 1'b1; req_valid = 2'b00; rnd_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $display("t3 drain%0d: out_valid=%b tag=%h", c, out_valid, out_tag);
      chk("t3_drain_valid", 32'(out_valid), (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) chk("t3_drain_tag", 32'(out_tag), 32'(c + 1));
      tick();
    end

    // ---- 4: randomness starvation ----
    do_reset();
    req_valid = 2'b10; req_tag = 8'h70;
    for (int c = 0; c < 9; c++) begin
      rnd_in_valid = (c % 3 == 0);
      rnd_in       = 15'(16'h40 + c / 3);
      @(negedge clk);
      $display("t4 cyc%0d: en_s1=%b core_rnd=%h", c, core_en_s1, core_rnd);
      chk("t4_issue", 32'(core_en_s1), (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c % 3 == 1) chk("t4_core_rnd", 32'(core_rnd), 32'h40 + 32'(c / 3));
      tick();
    end

    // ---- 5: reset mid-flight ----
    do_reset();
    rnd_in = 15'h300; rnd_in_valid = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 2'b01; req_tag = 8'h09;
    tick();
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("t5 async reset: out_valid=%b busy=%b", out_valid, busy);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_out_tag", 32'(out_tag), 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_no_ghost", 32'(out_valid), 32'd0);
      tick();
    end
    rnd_in = 15'h301; rnd_in_valid = 1'b1;
    tick();
    rnd_in_valid = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    $display("t5 first grant after reset: req_ready=%b", req_ready);
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    tick();
    idle();

`ifdef SOP_RND_CHK_EN
    // ---- 6: stuck PRNG ----
    do_reset();
    rnd_in = 15'hABC; rnd_in_valid = 1'b1;
    tick();
    req_valid = 2'b01; req_tag = 8'h0B;
    @(negedge clk);
    chk("t6_issue", 32'(req_ready), 32'h1);
    chk("t6_err_before", 32'(rnd_err), 32'd0);
    tick();
    rnd_in_valid = 1'b0;
    @(negedge clk);
    $display("t6 after repeat: rnd_err=%b req_ready=%b", rnd_err, req_ready);
    chk("t6_err_set", 32'(rnd_err), 32'd1);
    chk("t6_blocked", 32'(req_ready), 32'h0);
    chk("t6_drain_s2", 32'(core_en_s2), 32'd1);
    tick();
    @(negedge clk);
    chk("t6_blocked2", 32'(req_ready), 32'h0);
    chk("t6_delivered", 32'(out_valid), 32'd1);
    chk("t6_deliv_tag", 32'(out_tag), 32'hB);
    tick();
    idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
